// File: rtl/sprite_compositor.sv
// N-layer sprite compositor: per-pixel priority resolve with transparency keys and
// a frame-latched front override, double-buffered palette lookup, per-frame overlap mask.
module sprite_compositor #(
  parameter int unsigned                 NUM_LAYERS    = 2,
  parameter int unsigned                 COLOR_DEPTH   = 2,
  parameter int unsigned                 LAYER_IDX_W   = 2,
  parameter logic [9:0]                  FLOOR_Y       = 10'd440,
  parameter logic [COLOR_DEPTH-1:0]      BG_SKY_CODE   = 2'd3,
  parameter logic [COLOR_DEPTH-1:0]      BG_FLOOR_CODE = 2'd0,
  parameter logic [24*(2**COLOR_DEPTH)-1:0] RESET_PALETTE =
    {24'hFFFFFF, 24'h0000FF, 24'hFF0000, 24'h000000}
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              frame_start,
  input  logic                              pix_valid,
  input  logic [9:0]                        ycoord,
  input  logic [NUM_LAYERS*COLOR_DEPTH-1:0] layer_color,
  input  logic [NUM_LAYERS-1:0]             layer_active,
  input  logic [NUM_LAYERS*COLOR_DEPTH-1:0] layer_key,
  input  logic [LAYER_IDX_W-1:0]            front_layer,
  input  logic                              pal_wr_en,
  input  logic [COLOR_DEPTH-1:0]            pal_addr,
  input  logic [23:0]                       pal_data,
  output logic [7:0]                        vga_r,
  output logic [7:0]                        vga_g,
  output logic [7:0]                        vga_b,
  output logic                              pix_valid_out,
  output logic [NUM_LAYERS-1:0]             overlap_layers,
  output logic                              overlap_flag
);

  localparam int unsigned PAL_SIZE = 2 ** COLOR_DEPTH;

  logic [23:0]            shadow_pal [PAL_SIZE];
  logic [23:0]            active_pal [PAL_SIZE];
  logic [LAYER_IDX_W-1:0] front_q;
  logic [NUM_LAYERS-1:0]  opaque;
  logic                   multi_opaque;
  logic [COLOR_DEPTH-1:0] win_code;
  logic [COLOR_DEPTH-1:0] s1_code;
  logic                   s1_valid;
  logic [NUM_LAYERS-1:0]  acc_q;
  logic [NUM_LAYERS-1:0]  acc_next;

  always_comb begin
    int unsigned cnt;
    opaque = '0;
    cnt    = 0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      opaque[i] = layer_active[i] &
                  (layer_color[i*COLOR_DEPTH +: COLOR_DEPTH] != layer_key[i*COLOR_DEPTH +: COLOR_DEPTH]);
      if (opaque[i]) cnt = cnt + 1;
    end
    multi_opaque = (cnt >= 2);
  end

  // Lowest-index opaque layer wins unless the latched front layer is opaque;
  // an out-of-range front_q simply never matches a layer index.
  always_comb begin
    logic found;
    found    = 1'b0;
    win_code = (ycoord >= FLOOR_Y) ? BG_FLOOR_CODE : BG_SKY_CODE;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (opaque[i] && !found) begin
        win_code = layer_color[i*COLOR_DEPTH +: COLOR_DEPTH];
        found    = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (opaque[i] && (front_q == LAYER_IDX_W'(i)))
        win_code = layer_color[i*COLOR_DEPTH +: COLOR_DEPTH];
    end
  end

  always_comb begin
    acc_next = acc_q;
    if (pix_valid && multi_opaque) acc_next = acc_q | opaque;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      front_q        <= LAYER_IDX_W'(NUM_LAYERS);
      acc_q          <= '0;
      overlap_layers <= '0;
    end else begin
      if (frame_start) begin
        front_q        <= front_layer;
        overlap_layers <= acc_next;
        acc_q          <= '0;
      end else begin
        acc_q <= acc_next;
      end
    end
  end

  // A write coinciding with frame_start is forwarded into the committed entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < PAL_SIZE; i++) begin
        shadow_pal[i] <= RESET_PALETTE[i*24 +: 24];
        active_pal[i] <= RESET_PALETTE[i*24 +: 24];
      end
    end else begin
      if (pal_wr_en) shadow_pal[pal_addr] <= pal_data;
      if (frame_start) begin
        for (int unsigned i = 0; i < PAL_SIZE; i++) begin
          if (pal_wr_en && (pal_addr == COLOR_DEPTH'(i)))
            active_pal[i] <= pal_data;
          else
            active_pal[i] <= shadow_pal[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_code  <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_code  <= win_code;
      s1_valid <= pix_valid;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vga_r         <= '0;
      vga_g         <= '0;
      vga_b         <= '0;
      pix_valid_out <= 1'b0;
    end else begin
      pix_valid_out <= s1_valid;
      if (s1_valid) begin
        {vga_r, vga_g, vga_b} <= active_pal[s1_code];
      end else begin
        vga_r <= '0;
        vga_g <= '0;
        vga_b <= '0;
      end
    end
  end

  assign overlap_flag = |overlap_layers;

endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_sprite_compositor;
  localparam int NL = 2;
  localparam int CD = 2;
  localparam int LW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset, frame_start, pix_valid;
  logic [9:0]     ycoord;
  logic [NL*CD-1:0] layer_color, layer_key;
  logic [NL-1:0]  layer_active;
  logic [LW-1:0]  front_layer;
  logic           pal_wr_en;
  logic [CD-1:0]  pal_addr;
  logic [23:0]    pal_data;
  logic [7:0]     vga_r, vga_g, vga_b;
  logic           pix_valid_out;
  logic [NL-1:0]  overlap_layers;
  logic           overlap_flag;

  sprite_compositor #(
    .NUM_LAYERS(NL), .COLOR_DEPTH(CD), .LAYER_IDX_W(LW)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .pix_valid(pix_valid),
    .ycoord(ycoord), .layer_color(layer_color), .layer_active(layer_active),
    .layer_key(layer_key), .front_layer(front_layer), .pal_wr_en(pal_wr_en),
    .pal_addr(pal_addr), .pal_data(pal_data), .vga_r(vga_r), .vga_g(vga_g),
    .vga_b(vga_b), .pix_valid_out(pix_valid_out), .overlap_layers(overlap_layers),
    .overlap_flag(overlap_flag)
  );

  int errors = 0;
  int checks = 0;

  logic [23:0] m_shadow [4];
  logic [23:0] m_active [4];
  int          m_front;
  logic [NL-1:0] m_acc, m_ovl;
  int          m_code1;
  bit          m_valid1;
  logic [23:0] exp_rgb;
  bit          exp_pvo;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  function automatic void model_reset();
    m_shadow = '{24'h000000, 24'hFF0000, 24'h0000FF, 24'hFFFFFF};
    m_active = m_shadow;
    m_front  = NL;
    m_acc    = '0;
    m_ovl    = '0;
    m_code1  = 0;
    m_valid1 = 0;
    exp_rgb  = '0;
    exp_pvo  = 0;
  endfunction

  // Advance the model across the upcoming rising edge using current inputs.
  function automatic void model_edge();
    int c [NL];
    int k [NL];
    bit [NL-1:0] op;
    int cnt;
    int code;
    if (!reset) return;
    cnt = 0;
    for (int i = 0; i < NL; i++) begin
      c[i]  = int'(layer_color[i*CD +: CD]);
      k[i]  = int'(layer_key[i*CD +: CD]);
      op[i] = layer_active[i] && (c[i] != k[i]);
      cnt  += int'(op[i]);
    end
    code = (ycoord >= 10'd440) ? 0 : 3;
    for (int i = NL - 1; i >= 0; i--) if (op[i]) code = c[i];
    if (m_front < NL && op[m_front]) code = c[m_front];
    exp_pvo  = m_valid1;
    exp_rgb  = m_valid1 ? m_active[m_code1] : 24'h0;
    m_code1  = code;
    m_valid1 = pix_valid;
    if (pix_valid && cnt >= 2) m_acc |= op;
    if (frame_start) begin
      m_ovl = m_acc;
      m_acc = '0;
    end
    if (pal_wr_en) m_shadow[pal_addr] = pal_data;
    if (frame_start) begin
      m_active = m_shadow;
      m_front  = int'(front_layer);
    end
  endfunction

  always @(posedge clk) begin
    #2;
    chk("vga_rgb", {vga_r, vga_g, vga_b}, exp_rgb);
    chk("pix_valid_out", pix_valid_out, exp_pvo);
    chk("overlap_layers", overlap_layers, m_ovl);
    chk("overlap_flag", overlap_flag, |m_ovl);
  end

  task automatic tick();
    model_edge();
    @(posedge clk);
    #3;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic do_reset(input string name);
    reset = 1'b0;
    model_reset();
    #1;
    chk({name, "_rgb"}, {vga_r, vga_g, vga_b}, 24'h0);
    chk({name, "_pvo"}, pix_valid_out, 1'b0);
    chk({name, "_ovl"}, overlap_layers, 2'b00);
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; frame_start = 0; pix_valid = 0; ycoord = '0;
    layer_color = '0; layer_key = '0; layer_active = '0; front_layer = '0;
    pal_wr_en = 0; pal_addr = '0; pal_data = '0;
    model_reset();
    ticks(3);
    reset = 1'b1;

    // background sky / floor
    pix_valid = 1; ycoord = 10'd100;
    ticks(2);
    chk("sky_rgb", {vga_r, vga_g, vga_b}, 24'hFFFFFF);
    chk("sky_pvo", pix_valid_out, 1'b1);
    ycoord = 10'd450;
    ticks(2);
    chk("floor_rgb", {vga_r, vga_g, vga_b}, 24'h000000);
    ycoord = 10'd439;
    ticks(2);
    chk("y439_sky_rgb", {vga_r, vga_g, vga_b}, 24'hFFFFFF);

    // priority and front override
    ycoord = 10'd100;
    layer_color = {2'd2, 2'd1}; layer_key = {2'd1, 2'd2}; layer_active = 2'b11;
    front_layer = 2'd3;
    ticks(2);
    chk("prio_l0_rgb", {vga_r, vga_g, vga_b}, 24'hFF0000);
    front_layer = 2'd1;
    pulse_fs();
    chk("fs_ovl_11", overlap_layers, 2'b11);
    ticks(2);
    chk("front_l1_rgb", {vga_r, vga_g, vga_b}, 24'h0000FF);
    front_layer = 2'd0;
    ticks(3);
    chk("front_held_rgb", {vga_r, vga_g, vga_b}, 24'h0000FF);

    // transparent L0 gives no overlap
    front_layer = 2'd3;
    layer_color = {2'd1, 2'd2}; layer_key = {2'd0, 2'd2};
    pulse_fs();
    ticks(4);
    chk("transp_rgb", {vga_r, vga_g, vga_b}, 24'hFF0000);
    pulse_fs();
    chk("transp_ovl", overlap_layers, 2'b00);

    // three overlapping pixels, then a clean frame
    layer_color = {2'd2, 2'd1}; layer_key = {2'd0, 2'd0};
    ticks(3);
    pix_valid = 0;
    pulse_fs();
    chk("ovl3_layers", overlap_layers, 2'b11);
    chk("ovl3_flag", overlap_flag, 1'b1);
    pix_valid = 1; layer_active = 2'b01;
    ticks(4);
    pulse_fs();
    chk("clean_ovl", overlap_layers, 2'b00);
    chk("clean_flag", overlap_flag, 1'b0);

    // palette double buffering
    layer_color = {2'd0, 2'd1}; layer_key = '0; layer_active = 2'b01;
    pal_wr_en = 1; pal_addr = 2'd1; pal_data = 24'h00FF00;
    tick();
    pal_wr_en = 0;
    ticks(2);
    chk("pal_mid_rgb", {vga_r, vga_g, vga_b}, 24'hFF0000);
    pulse_fs();
    ticks(2);
    chk("pal_commit_rgb", {vga_r, vga_g, vga_b}, 24'h00FF00);
    pal_wr_en = 1; pal_data = 24'h123456;
    pulse_fs();
    pal_wr_en = 0;
    ticks(2);
    chk("pal_coinc_rgb", {vga_r, vga_g, vga_b}, 24'h123456);

    // mid-frame reset with pending palette write and overlap
    pal_wr_en = 1; pal_data = 24'hABCDEF; layer_active = 2'b11;
    layer_color = {2'd1, 2'd1}; layer_key = {2'd2, 2'd2};
    tick();
    pal_wr_en = 0;
    do_reset("midrst");
    layer_active = 2'b01;
    ticks(2);
    chk("post_rst_rgb", {vga_r, vga_g, vga_b}, 24'hFF0000);
    chk("post_rst_ovl", overlap_layers, 2'b00);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      layer_color  = NL*CD'($urandom);
      layer_key    = ($urandom_range(0, 2) == 0) ? layer_color : NL*CD'($urandom);
      layer_active = NL'($urandom);
      ycoord       = 10'($urandom_range(0, 599));
      front_layer  = LW'($urandom);
      pix_valid    = ($urandom_range(0, 4) != 0);
      frame_start  = ($urandom_range(0, 39) == 0);
      pal_wr_en    = ($urandom_range(0, 5) == 0);
      pal_addr     = CD'($urandom);
      pal_data     = 24'($urandom);
      if ($urandom_range(0, 599) == 0) do_reset("rnd_rst");
      else tick();
    end

    frame_start = 0; pal_wr_en = 0;
    ticks(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
Parametrised N-layer pixel compositor, the next generation of the two-player draw stage. Takes per-layer colour codes and active flags from the sprite renderers and resolves per-pixel priority with a per-layer transparency key and a frame-latched "bring to front" override. Maps the winning code through a double-buffered, writable 24-bit palette and accumulates a per-frame layer-overlap (hit) mask for game logic. Sits between the sprite_renderer instances and the VGA output.

Parameters:
NUM_LAYERS, 2, number of sprite layers; index 0 has highest default priority
COLOR_DEPTH, 2, bits per colour code; palette has 2^COLOR_DEPTH entries
LAYER_IDX_W, 2, width of front_layer; must satisfy 2^LAYER_IDX_W > NUM_LAYERS
FLOOR_Y, 10'd440, first ycoord drawn with the floor background
BG_SKY_CODE, 2'd3, background code for ycoord < FLOOR_Y
BG_FLOOR_CODE, 2'd0, background code for ycoord >= FLOOR_Y
RESET_PALETTE, {24'hFFFFFF,24'h0000FF,24'hFF0000,24'h000000}, packed reset palette; entry i = bits [24i+23:24i]

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous, active-low reset
frame_start  in  1  single-cycle pulse at start of vertical blank
pix_valid  in  1  current pixel is in the active display area
ycoord  in  10  current pixel row
layer_color  in  NUM_LAYERS*COLOR_DEPTH  packed colour codes; layer i at [i*COLOR_DEPTH +: COLOR_DEPTH]
layer_active  in  NUM_LAYERS  layer i covers the current pixel
layer_key  in  NUM_LAYERS*COLOR_DEPTH  per-layer transparent colour code
front_layer  in  LAYER_IDX_W  layer forced to front; values >= NUM_LAYERS mean no override
pal_wr_en  in  1  palette shadow write strobe
pal_addr  in  COLOR_DEPTH  palette entry to write
pal_data  in  24  RGB888 value to write
vga_r / vga_g / vga_b  out  8 each  composited pixel colour
pix_valid_out  out  1  pix_valid delayed to align with vga_*
overlap_layers  out  NUM_LAYERS  layers that were opaque on a pixel shared with another opaque layer during the previous frame
overlap_flag  out  1  OR-reduction of overlap_layers

Behaviour:
- Reset (reset low, async): vga_* = 0, pix_valid_out = 0, overlap_layers = 0, overlap accumulator = 0, latched front = NUM_LAYERS (no override), shadow and active palettes = RESET_PALETTE.
- Opaque mask: opaque[i] = layer_active[i] & (layer_color[i] != layer_key[i]).
- Front latch: front_layer is sampled only on a frame_start cycle; it is constant for the whole following frame. An out-of-range value disables the override.
- Stage 1 (registered): winning code = latched front layer's colour if that layer is opaque; otherwise the lowest-index opaque layer's colour; otherwise background (BG_FLOOR_CODE if ycoord >= FLOOR_Y, else BG_SKY_CODE). pix_valid is registered alongside.
- Stage 2 (registered): rgb = active_palette[code]; outputs zero when the stage-1 valid is 0. Latency is exactly 2 cycles from inputs to vga_*/pix_valid_out; throughput is one pixel per clock with no stalls.
- Palette: pal_wr_en writes shadow[pal_addr] = pal_data on the clock edge, with no back-pressure. On frame_start the whole active palette is copied from shadow. A write coinciding with frame_start lands in the shadow, and the committed active entry holds the new pal_data. Writes never affect the active palette mid-frame.
- Overlap: on a pix_valid cycle with popcount(opaque) >= 2, acc |= opaque. On frame_start, overlap_layers <= acc (including the current cycle's contribution if pix_valid is also high) and acc clears to 0. overlap_layers holds for the full frame. overlap_flag is combinational from overlap_layers.
- Mid-frame reset clears everything immediately. Until the next frame_start, compositing uses the reset palette and no override.

Test Plan:
- Reset then pix_valid=1, NUM_LAYERS=2, both layers inactive, ycoord=100 -> two cycles later pix_valid_out=1, rgb=FFFFFF (sky code 3); at ycoord=450 -> rgb=000000.
- L0 colour 1, key 2, active; L1 colour 2, key 1, active; front_layer=3 -> rgb=FF0000. Then front_layer=1 with frame_start -> next frame rgb=0000FF. front_layer changed without frame_start -> no change.
- L0 colour=key=2 (transparent), L1 colour 1 opaque -> rgb=FF0000, and overlap acc stays 0.
- Both layers opaque on 3 pixels in a frame, then frame_start -> overlap_layers=2'b11, overlap_flag=1. A following frame with no overlap, then frame_start -> overlap_layers=0.
- pal_wr_en addr=1 data=00FF00 mid-frame -> code-1 pixels stay FF0000 until frame_start, then 00FF00. A write coincident with frame_start takes effect in the next frame.
- Reset asserted mid-frame while overlap and palette are modified -> all outputs 0 immediately; after release, code 1 maps to FF0000.
